read_pointer_empty: RTL and testbench

Read-domain pointer and status stage of the asynchronous FIFO. It takes the Gray-coded write pointer after its two-flop synchronisation into read_clk. It maintains the read pointer in both binary and Gray form, and drives the FIFO memory read address. It also produces the empty, almost-empty, fill-count and underflow status flags. Its Gray read pointer output feeds the read-to-write synchroniser on the write side.

---
 rtl/read_pointer_empty.sv | 84 ++++++++
 tb/tb_read_pointer_empty.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/read_pointer_empty.sv
// Read-domain pointer and status stage of an asynchronous FIFO.
// Keeps the read pointer in binary and Gray form, decodes the synchronised
// Gray write pointer, and produces empty, almost-empty, fill-count and a
// sticky underflow flag. Status flags are computed from next-state pointer
// values so a pop of the last word raises empty on the same edge.
module read_pointer_empty #(
    parameter int address_size       = 3,
    parameter int almost_empty_level = 1
) (
    input  logic                    read_clk,
    input  logic                    read_reset_n,
    input  logic                    read_increment,
    input  logic [address_size:0]   read_to_write_pointer,
    output logic [address_size-1:0] read_address,
    output logic [address_size:0]   read_pointer,
    output logic                    read_empty,
    output logic                    read_almost_empty,
    output logic [address_size:0]   read_count,
    output logic                    read_underflow
);

    localparam int PW = address_size + 1;
    localparam logic [PW-1:0] AE_LEVEL = PW'(almost_empty_level);

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic          empty_q, empty_d;
    logic          almost_empty_q, almost_empty_d;
    logic [PW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;
    logic [PW-1:0] wbin;
    logic          read_accept;

    // Decode the synchronised Gray write pointer to binary (MSB-down XOR prefix).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        wbin = '0;
        wbin[PW-1] = read_to_write_pointer[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ read_to_write_pointer[i];
        end
    end

    // Next-state pointers and status flags, all derived from the advanced pointer.
    always_comb begin
        read_accept    = read_increment & ~empty_q;
        rbin_d         = rbin_q + PW'(read_accept);
        rgray_d        = (rbin_d >> 1) ^ rbin_d;
        empty_d        = (rgray_d == read_to_write_pointer);
        count_d        = wbin - rbin_d;
        almost_empty_d = (count_d <= AE_LEVEL);
        underflow_d    = underflow_q | (read_increment & empty_q);
    end

    // State register: pointers and flags, cleared asynchronously to the empty state.
    always_ff @(posedge read_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            rbin_q         <= '0;
            rgray_q        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            count_q        <= '0;
            underflow_q    <= 1'b0;
        end else begin
            rbin_q         <= rbin_d;
            rgray_q        <= rgray_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            count_q        <= count_d;
            underflow_q    <= underflow_d;
        end
    end

    assign read_address      = rbin_q[address_size-1:0];
    assign read_pointer      = rgray_q;
    assign read_empty        = empty_q;
    assign read_almost_empty = almost_empty_q;
    assign read_count        = count_q;
    assign read_underflow    = underflow_q;

endmodule

// File: tb/tb_read_pointer_empty.sv
// Directed bench for read_pointer_empty (address_size = 3, almost_empty_level = 1).
module tb_read_pointer_empty;

    logic       read_clk = 1'b0;
    logic       read_reset_n;
    logic       read_increment;
    logic [3:0] read_to_write_pointer;
    logic [2:0] read_address;
    logic [3:0] read_pointer;
    logic       read_empty;
    logic       read_almost_empty;
    logic [3:0] read_count;
    logic       read_underflow;

    int vectors     = 0;
    int miscompares = 0;

    read_pointer_empty #(.address_size(3), .almost_empty_level(1)) dut (
        .read_clk              (read_clk),
        .read_reset_n          (read_reset_n),
        .read_increment        (read_increment),
        .read_to_write_pointer (read_to_write_pointer),
        .read_address          (read_address),
        .read_pointer          (read_pointer),
        .read_empty            (read_empty),
        .read_almost_empty     (read_almost_empty),
        .read_count            (read_count),
        .read_underflow        (read_underflow)
    );

    always #5 read_clk = ~read_clk;

    function automatic logic [3:0] gray(input int n);
        logic [3:0] b;
        b = 4'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One rising edge, then settle before sampling outputs.
    task automatic step();
        @(posedge read_clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"}, 32'(read_empty), 32'd1);
        check({tag, "_aempty"}, 32'(read_almost_empty), 32'd1);
        check({tag, "_count"}, 32'(read_count), 32'd0);
        check({tag, "_addr"}, 32'(read_address), 32'd0);
        check({tag, "_rptr"}, 32'(read_pointer), 32'd0);
        check({tag, "_uflow"}, 32'(read_underflow), 32'd0);
    endtask

    initial begin
        read_reset_n          = 1'b0;
        read_increment        = 1'b0;
        read_to_write_pointer = 4'b0000;
        #12;
        check_reset_state("rst");
        @(negedge read_clk);
        read_reset_n = 1'b1;

        // Three words appear, no reads.
        read_to_write_pointer = 4'b0010;
        step();
        check("fill3_empty", 32'(read_empty), 32'd0);
        check("fill3_count", 32'(read_count), 32'd3);
        check("fill3_aempty", 32'(read_almost_empty), 32'd0);

        // Pop two.
        read_increment = 1'b1;
        step();
        check("pop1_count", 32'(read_count), 32'd2);
        step();
        check("pop2_count", 32'(read_count), 32'd1);
        check("pop2_aempty", 32'(read_almost_empty), 32'd1);
        check("pop2_addr", 32'(read_address), 32'd2);

        // Pop the last word: empty rises on the same edge.
        step();
        check("pop3_empty", 32'(read_empty), 32'd1);
        check("pop3_count", 32'(read_count), 32'd0);
        check("pop3_rptr", 32'(read_pointer), 32'b0010);
        check("pop3_uflow", 32'(read_underflow), 32'd0);

        // Pop while empty for two cycles.
        step();
        step();
        check("uf_rptr_hold", 32'(read_pointer), 32'b0010);
        check("uf_addr_hold", 32'(read_address), 32'd3);
        check("uf_flag", 32'(read_underflow), 32'd1);

        // Writes arrive: underflow stays sticky.
        read_increment        = 1'b0;
        read_to_write_pointer = 4'b0111;
        step();
        check("uf_after_wr_empty", 32'(read_empty), 32'd0);
        check("uf_after_wr_count", 32'(read_count), 32'd2);
        check("uf_sticky", 32'(read_underflow), 32'd1);

        // Reset pulse clears everything.
        read_to_write_pointer = 4'b0000;
        read_reset_n          = 1'b0;
        #2;
        check_reset_state("rst2");
        @(negedge read_clk);
        read_reset_n = 1'b1;

        // Wrap: 16 single writes, each read back.
        for (int i = 0; i < 16; i++) begin
            read_increment        = 1'b0;
            read_to_write_pointer = gray(i + 1);
            step();
            check($sformatf("wrap%0d_addr", i), 32'(read_address), 32'(i % 8));
            check($sformatf("wrap%0d_count", i), 32'(read_count), 32'd1);
            check($sformatf("wrap%0d_nempty", i), 32'(read_empty), 32'd0);
            if (i == 15) begin
                check("wrap_rptr_top", 32'(read_pointer), 32'b1000);
            end
            read_increment = 1'b1;
            step();
            check($sformatf("wrap%0d_empty", i), 32'(read_empty), 32'd1);
            check($sformatf("wrap%0d_rptr", i), 32'(read_pointer), 32'(gray((i + 1) % 16)));
        end
        read_increment = 1'b0;
        check("wrap_end_rptr", 32'(read_pointer), 32'b0000);
        check("wrap_end_uflow", 32'(read_underflow), 32'd0);

        // Full then drain.
        read_to_write_pointer = 4'b1100;
        step();
        check("full_count", 32'(read_count), 32'd8);
        check("full_empty", 32'(read_empty), 32'd0);
        check("full_aempty", 32'(read_almost_empty), 32'd0);
        read_increment = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("drain%0d_count", k), 32'(read_count), 32'(8 - k));
            check($sformatf("drain%0d_empty", k), 32'(read_empty), (k == 8) ? 32'd1 : 32'd0);
            check($sformatf("drain%0d_aempty", k), 32'(read_almost_empty), (k >= 7) ? 32'd1 : 32'd0);
        end
        read_increment = 1'b0;
        check("drain_rptr", 32'(read_pointer), 32'b1100);

        // Simultaneous write and read at count 1.
        read_to_write_pointer = gray(9);
        step();
        check("sim_pre_count", 32'(read_count), 32'd1);
        read_to_write_pointer = gray(10);
        read_increment        = 1'b1;
        step();
        check("sim_count", 32'(read_count), 32'd1);
        check("sim_empty", 32'(read_empty), 32'd0);
        check("sim_rptr", 32'(read_pointer), 32'(gray(9)));
        read_increment = 1'b0;

        // Asynchronous reset mid-stream, sampled before the next edge.
        #1;
        read_reset_n = 1'b0;
        #1;
        check_reset_state("rst3");
        read_to_write_pointer = 4'b0000;
        @(negedge read_clk);
        read_reset_n = 1'b1;
        step();
        check("post_rst_empty", 32'(read_empty), 32'd1);
        check("post_rst_count", 32'(read_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
